// File: rtl/uart_reg_pkg.sv
// Shared register map and host FSM states for the UART register port.
// Imported by the UART and by its bus initiator.
package uart_reg_pkg;

  localparam int unsigned ADDR_DATA           = 0;
  localparam int unsigned ADDR_STATUS         = 1;
  localparam int unsigned STATUS_TX_BUSY_BIT  = 0;
  localparam int unsigned STATUS_RX_AVAIL_BIT = 1;
  localparam logic [7:0]  RX_ACK_MASK         = 8'h02;

  typedef enum logic [2:0] {
    POLL,
    POLL_WAIT,
    DECIDE,
    RD_DATA,
    RD_ACK,
    WR_DATA,
    GAP
  } host_state_t;

endpackage

// File: rtl/uart_reg_skid.sv
// One-deep valid/ready holding register; in_ready, out_valid and out_data are all registered.
module uart_reg_skid #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic load;
  logic unload;
  logic full_next;

  assign load      = in_valid && in_ready;
  assign unload    = out_valid && out_ready;
  assign full_next = load || (out_valid && !unload);

  // in_ready is the registered complement of the next occupancy, low while in reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= full_next;
      in_ready  <= !full_next;
      if (load) out_data <= in_data;
    end
  end

endmodule

// File: rtl/uart_reg_host.sv
// Bus initiator for the UART register port: polls status, pushes TX bytes in,
// pulls RX bytes out and acknowledges them.
module uart_reg_host
  import uart_reg_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned POLL_GAP   = 0
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_wrEnable,
  output logic [DATA_WIDTH-1:0] o_wrData,
  input  logic [DATA_WIDTH-1:0] i_rdData,
  input  logic [DATA_WIDTH-1:0] i_txData,
  input  logic                  i_txValid,
  output logic                  o_txReady,
  output logic [DATA_WIDTH-1:0] o_rxData,
  output logic                  o_rxValid,
  input  logic                  i_rxReady
);

  localparam int unsigned LAT_W = $clog2(RD_LATENCY + 1);
  localparam int unsigned GAP_W = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
  localparam host_state_t      AFTER_XFER = (POLL_GAP == 0) ? POLL : GAP;

  host_state_t           state, state_d;
  logic [LAT_W-1:0]      lat_cnt, lat_cnt_d;
  logic [GAP_W-1:0]      gap_cnt, gap_cnt_d;
  logic                  stat_busy, stat_busy_d;
  logic                  stat_avail, stat_avail_d;
  logic                  prio_rx, prio_rx_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  we_d;
  logic [DATA_WIDTH-1:0] wd_d;
  logic                  rx_cand, tx_cand;
  logic                  tx_full, tx_pop;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  rx_capture, rx_in_ready;

  uart_reg_skid #(.WIDTH(DATA_WIDTH)) u_tx_hold (
    .clk       (i_clock),
    .rst       (i_reset),
    .in_data   (i_txData),
    .in_valid  (i_txValid),
    .in_ready  (o_txReady),
    .out_data  (tx_data),
    .out_valid (tx_full),
    .out_ready (tx_pop)
  );

  uart_reg_skid #(.WIDTH(DATA_WIDTH)) u_rx_hold (
    .clk       (i_clock),
    .rst       (i_reset),
    .in_data   (i_rdData),
    .in_valid  (rx_capture),
    .in_ready  (rx_in_ready),
    .out_data  (o_rxData),
    .out_valid (o_rxValid),
    .out_ready (i_rxReady)
  );

  assign tx_pop     = (state == WR_DATA);
  assign rx_capture = (state == RD_DATA) && (lat_cnt == '0) && rx_in_ready;

  // Next state, then the bus outputs belonging to that next state so they come out registered
  always_comb begin
    state_d      = state;
    lat_cnt_d    = lat_cnt;
    gap_cnt_d    = gap_cnt;
    stat_busy_d  = stat_busy;
    stat_avail_d = stat_avail;
    prio_rx_d    = prio_rx;
    rx_cand      = stat_avail && !o_rxValid;
    tx_cand      = !stat_busy && tx_full;

    case (state)
      POLL: begin
        state_d   = POLL_WAIT;
        lat_cnt_d = LAT_W'(RD_LATENCY);
      end
      POLL_WAIT: begin
        if (lat_cnt == '0) begin
          stat_busy_d  = i_rdData[STATUS_TX_BUSY_BIT];
          stat_avail_d = i_rdData[STATUS_RX_AVAIL_BIT];
          state_d      = DECIDE;
        end else begin
          lat_cnt_d = lat_cnt - 1'b1;
        end
      end
      DECIDE: begin
        if (rx_cand && (!tx_cand || prio_rx)) begin
          state_d   = RD_DATA;
          lat_cnt_d = LAT_W'(RD_LATENCY);
          prio_rx_d = 1'b0;
        end else if (tx_cand) begin
          state_d   = WR_DATA;
          prio_rx_d = 1'b1;
        end else begin
          state_d = AFTER_XFER;
        end
      end
      RD_DATA: begin
        if (lat_cnt == '0) state_d = RD_ACK;
        else lat_cnt_d = lat_cnt - 1'b1;
      end
      RD_ACK:  state_d = AFTER_XFER;
      WR_DATA: state_d = AFTER_XFER;
      GAP: begin
        if (gap_cnt == '0) state_d = POLL;
        else gap_cnt_d = gap_cnt - 1'b1;
      end
      default: state_d = POLL;
    endcase

    if ((state_d == GAP) && (state != GAP)) gap_cnt_d = GAP_LOAD;

    addr_d = ADDR_WIDTH'(ADDR_STATUS);
    we_d   = 1'b0;
    wd_d   = '0;
    case (state_d)
      RD_DATA: addr_d = ADDR_WIDTH'(ADDR_DATA);
      RD_ACK: begin
        we_d = 1'b1;
        wd_d = DATA_WIDTH'(RX_ACK_MASK);
      end
      WR_DATA: begin
        addr_d = ADDR_WIDTH'(ADDR_DATA);
        we_d   = 1'b1;
        wd_d   = tx_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state      <= POLL;
      lat_cnt    <= '0;
      gap_cnt    <= '0;
      stat_busy  <= 1'b0;
      stat_avail <= 1'b0;
      prio_rx    <= 1'b1;
      o_addr     <= ADDR_WIDTH'(ADDR_STATUS);
      o_wrEnable <= 1'b0;
      o_wrData   <= '0;
    end else begin
      state      <= state_d;
      lat_cnt    <= lat_cnt_d;
      gap_cnt    <= gap_cnt_d;
      stat_busy  <= stat_busy_d;
      stat_avail <= stat_avail_d;
      prio_rx    <= prio_rx_d;
      o_addr     <= addr_d;
      o_wrEnable <= we_d;
      o_wrData   <= wd_d;
    end
  end

endmodule

// File: tb/tb_uart_reg_host.sv
// Self-checking bench for uart_reg_host: a behavioural UART (RX byte queue, TX busy flag,
// pipelined read port) plus stream source/sink scoreboards.
module tb_uart_reg_host;
  import uart_reg_pkg::*;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned LAT   = 2;
  localparam int unsigned GAPN  = 1;
  localparam int unsigned POLLP = LAT + 3 + GAPN;
  localparam int unsigned BOUND = 4 * POLLP + 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] o_addr;
  logic          o_wrEnable;
  logic [DW-1:0] o_wrData;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          o_txReady;
  logic [DW-1:0] o_rxData;
  logic          o_rxValid;
  logic          rx_ready;

  int vectors    = 0;
  int miscompares = 0;

  logic [7:0] rx_q[$];     // bytes waiting inside the modelled UART receiver
  logic [7:0] exp_rx[$];   // every byte the UART received, in order
  logic [7:0] rcv_q[$];    // bytes handed out on the RX stream
  logic [7:0] src_q[$];    // bytes still to offer on the TX stream
  logic [7:0] exp_tx[$];   // bytes accepted by the TX stream
  logic [7:0] tx_log[$];   // DATA writes seen on the bus
  logic [7:0] svc_log[$];  // "R" per RX ack write, "T" per TX data write
  logic       tx_busy = 1'b0;
  int         rx_ready_mode = 0;

  logic [7:0]    pipe [LAT];
  logic [7:0]    cur;
  logic          we_seen, prev_we;
  logic [AW-1:0] wa_seen;
  logic [DW-1:0] wd_seen;

  always #5 clk = ~clk;

  uart_reg_host #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT), .POLL_GAP(GAPN)) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .o_addr     (o_addr),
    .o_wrEnable (o_wrEnable),
    .o_wrData   (o_wrData),
    .i_rdData   (rd_data),
    .i_txData   (tx_data),
    .i_txValid  (tx_valid),
    .o_txReady  (o_txReady),
    .o_rxData   (o_rxData),
    .o_rxValid  (o_rxValid),
    .i_rxReady  (rx_ready)
  );

  // UART read port: data for the address presented LAT clocks earlier
  initial begin
    rd_data = '0;
    for (int i = 0; i < LAT; i++) pipe[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (o_addr == AW'(ADDR_DATA)) cur = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
      else cur = {6'b0, (rx_q.size() != 0), tx_busy};
      rd_data = pipe[LAT-1];
      for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = cur;
    end
  end

  // UART write port: a write takes effect at the clock edge ending its strobe cycle
  initial begin
    prev_we = 1'b0;
    forever begin
      @(negedge clk);
      we_seen = o_wrEnable;
      wa_seen = o_addr;
      wd_seen = o_wrData;
      @(posedge clk);
      if (we_seen && !rst) begin
        vectors++;
        if (wa_seen == AW'(ADDR_DATA)) begin
          tx_log.push_back(wd_seen);
          svc_log.push_back("T");
        end else if (wa_seen == AW'(ADDR_STATUS) && wd_seen == RX_ACK_MASK) begin
          if (rx_q.size() != 0) void'(rx_q.pop_front());
          svc_log.push_back("R");
        end else begin
          miscompares++;
          $display("FAIL bus_write: addr %0h data %0h, required addr 0 or addr 1 with data 02", wa_seen, wd_seen);
        end
        if (prev_we) begin
          miscompares++;
          $display("FAIL strobe_width: o_wrEnable high 2 clocks, required 1");
        end
      end
      prev_we = we_seen && !rst;
    end
  end

  // Stream source and sink
  initial begin
    tx_valid = 1'b0;
    tx_data  = '0;
    rx_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rx_ready_mode)
        0:       rx_ready = 1'b0;
        1:       rx_ready = 1'b1;
        default: rx_ready = 1'($urandom_range(0, 1));
      endcase
      if (o_rxValid && rx_ready && !rst) rcv_q.push_back(o_rxData);
      tx_valid = (src_q.size() != 0);
      tx_data  = tx_valid ? src_q[0] : 8'h00;
      if (tx_valid && o_txReady && !rst) exp_tx.push_back(src_q.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_model();
    rx_q.delete(); exp_rx.delete(); rcv_q.delete(); src_q.delete();
    exp_tx.delete(); tx_log.delete(); svc_log.delete();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int bad_addr = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors += 6;
    if (o_addr !== AW'(ADDR_STATUS)) begin miscompares++; $display("FAIL reset_addr: got %0h want 1", o_addr); end
    if (o_wrEnable !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b want 0", o_wrEnable); end
    if (o_wrData !== 8'h00) begin miscompares++; $display("FAIL reset_wdata: got %0h want 0", o_wrData); end
    if (o_txReady !== 1'b0) begin miscompares++; $display("FAIL reset_txready: got %b want 0", o_txReady); end
    if (o_rxValid !== 1'b0) begin miscompares++; $display("FAIL reset_rxvalid: got %b want 0", o_rxValid); end
    if (o_rxData !== 8'h00) begin miscompares++; $display("FAIL reset_rxdata: got %0h want 0", o_rxData); end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (o_txReady !== 1'b1) begin miscompares++; $display("FAIL txready_after_reset: got %b want 1", o_txReady); end
    repeat (5 * POLLP) begin
      @(negedge clk);
      if (o_addr !== AW'(ADDR_STATUS)) bad_addr++;
    end
    vectors += 2;
    if (bad_addr != 0) begin miscompares++; $display("FAIL idle_addr: %0d clocks off ADDR_STATUS, want 0", bad_addr); end
    if (svc_log.size() != 0) begin miscompares++; $display("FAIL idle_writes: got %0d writes want 0", svc_log.size()); end
  endtask

  task automatic test_tx_single();
    int  n;
    int  early = 0;
    logic acc_prev = 1'b0;
    clear_model();
    reset_dut();
    src_q.push_back(8'hA5);
    for (n = 0; n < BOUND && tx_log.size() == 0; n++) begin
      @(negedge clk);
      if (tx_log.size() == 0 && acc_prev && o_txReady) early++;
      acc_prev = (exp_tx.size() != 0);
    end
    vectors += 4;
    if (n >= BOUND) begin miscompares++; $display("FAIL tx_single_timeout: no write within %0d clocks", BOUND); end
    if (early != 0) begin miscompares++; $display("FAIL tx_ready_held: high %0d clocks while full, want 0", early); end
    if (o_txReady !== 1'b1) begin miscompares++; $display("FAIL tx_ready_rise: got %b want 1 after write", o_txReady); end
    if (tx_log.size() != 0 && tx_log[0] !== 8'hA5) begin miscompares++; $display("FAIL tx_single_data: got %0h want a5", tx_log[0]); end
    repeat (3 * POLLP) @(negedge clk);
    vectors++;
    if (tx_log.size() != 1) begin miscompares++; $display("FAIL tx_single_count: got %0d writes want 1", tx_log.size()); end
  endtask

  task automatic test_tx_busy();
    clear_model();
    tx_busy = 1'b1;
    src_q.push_back(8'h3C);
    repeat (10 * POLLP) @(negedge clk);
    vectors += 2;
    if (tx_log.size() != 0) begin miscompares++; $display("FAIL tx_busy_hold: got %0d writes want 0", tx_log.size()); end
    if (exp_tx.size() != 1) begin miscompares++; $display("FAIL tx_busy_accept: got %0d accepted want 1", exp_tx.size()); end
    tx_busy = 1'b0;
    repeat (BOUND) @(negedge clk);
    vectors += 2;
    if (tx_log.size() != 1) begin miscompares++; $display("FAIL tx_busy_count: got %0d writes want 1", tx_log.size()); end
    if (tx_log.size() != 0 && tx_log[0] !== 8'h3C) begin miscompares++; $display("FAIL tx_busy_data: got %0h want 3c", tx_log[0]); end
  endtask

  task automatic test_rx_single();
    int n;
    clear_model();
    rx_ready_mode = 1;
    rx_q.push_back(8'h7E);
    for (n = 0; n < BOUND && svc_log.size() == 0; n++) @(negedge clk);
    vectors += 4;
    if (n >= BOUND) begin miscompares++; $display("FAIL rx_single_timeout: no ack within %0d clocks", BOUND); end
    if (rcv_q.size() != 1) begin miscompares++; $display("FAIL rx_single_count: got %0d bytes want 1", rcv_q.size()); end
    else if (rcv_q[0] !== 8'h7E) begin miscompares++; $display("FAIL rx_single_data: got %0h want 7e", rcv_q[0]); end
    if (svc_log.size() != 0 && svc_log[0] !== "R") begin miscompares++; $display("FAIL rx_ack_kind: got %0h want R", svc_log[0]); end
    if (rx_q.size() != 0) begin miscompares++; $display("FAIL rx_ack_clear: %0d bytes left in UART want 0", rx_q.size()); end
    repeat (3 * POLLP) @(negedge clk);
    vectors++;
    if (rcv_q.size() != 1) begin miscompares++; $display("FAIL rx_single_dup: got %0d bytes want 1", rcv_q.size()); end
  endtask

  task automatic test_alternate();
    int n;
    clear_model();
    rx_ready_mode = 1;
    for (int i = 0; i < 8; i++) begin
      cur = 8'($urandom);
      rx_q.push_back(cur);
      exp_rx.push_back(cur);
      src_q.push_back(8'($urandom));
    end
    reset_dut();
    for (n = 0; n < 20 * BOUND && svc_log.size() < 16; n++) @(negedge clk);
    vectors++;
    if (svc_log.size() < 8) begin miscompares++; $display("FAIL alt_timeout: got %0d services want 8", svc_log.size()); end
    for (int i = 0; i < 8 && i < svc_log.size(); i++) begin
      vectors++;
      if (svc_log[i] !== ((i % 2 == 0) ? "R" : "T")) begin
        miscompares++;
        $display("FAIL alt_order[%0d]: got %0h want %0h", i, svc_log[i], (i % 2 == 0) ? "R" : "T");
      end
    end
    repeat (2 * POLLP) @(negedge clk);
    vectors += 2;
    if (rcv_q != exp_rx) begin miscompares++; $display("FAIL alt_rx_stream: got %0d bytes want %0d in order", rcv_q.size(), exp_rx.size()); end
    if (tx_log != exp_tx) begin miscompares++; $display("FAIL alt_tx_stream: got %0d writes want %0d in order", tx_log.size(), exp_tx.size()); end
  endtask

  task automatic test_reset_midop();
    int n;
    clear_model();
    rx_ready_mode = 1;
    rx_q.push_back(8'h55);
    exp_rx.push_back(8'h55);
    for (n = 0; n < BOUND && !(o_addr == AW'(ADDR_DATA) && !o_wrEnable); n++) @(negedge clk);
    rst = 1'b1;
    #1;
    vectors += 4;
    if (n >= BOUND) begin miscompares++; $display("FAIL rst_rd_timeout: no RD_DATA within %0d clocks", BOUND); end
    if (o_wrEnable !== 1'b0) begin miscompares++; $display("FAIL rst_rd_we: got %b want 0", o_wrEnable); end
    if (o_rxValid !== 1'b0) begin miscompares++; $display("FAIL rst_rd_rxvalid: got %b want 0", o_rxValid); end
    if (o_addr !== AW'(ADDR_STATUS)) begin miscompares++; $display("FAIL rst_rd_addr: got %0h want 1", o_addr); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rcv_q.delete();
    for (n = 0; n < 2 * BOUND && rcv_q.size() == 0; n++) @(negedge clk);
    repeat (POLLP) @(negedge clk);
    vectors++;
    if (rcv_q != exp_rx) begin miscompares++; $display("FAIL rst_rd_recover: got %0d bytes want 1 byte 55", rcv_q.size()); end

    clear_model();
    src_q.push_back(8'h99);
    for (n = 0; n < 2 * BOUND && !(o_wrEnable && o_addr == AW'(ADDR_DATA)); n++) @(negedge clk);
    rst = 1'b1;
    #1;
    vectors += 3;
    if (n >= 2 * BOUND) begin miscompares++; $display("FAIL rst_wr_timeout: no WR_DATA within %0d clocks", 2 * BOUND); end
    if (o_wrEnable !== 1'b0) begin miscompares++; $display("FAIL rst_wr_we: got %b want 0", o_wrEnable); end
    if (o_wrData !== 8'h00) begin miscompares++; $display("FAIL rst_wr_wdata: got %0h want 0", o_wrData); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (BOUND) @(negedge clk);
    vectors++;
    if (tx_log.size() != 0) begin miscompares++; $display("FAIL rst_wr_partial: got %0d writes want 0", tx_log.size()); end
  endtask

  task automatic test_random();
    int n;
    clear_model();
    rx_ready_mode = 2;
    repeat (1500) begin
      @(negedge clk);
      if (rx_q.size() < 3 && $urandom_range(0, 5) == 0) begin
        cur = 8'($urandom);
        rx_q.push_back(cur);
        exp_rx.push_back(cur);
      end
      if (src_q.size() < 3 && $urandom_range(0, 4) == 0) src_q.push_back(8'($urandom));
      if ($urandom_range(0, 9) == 0) tx_busy = ~tx_busy;
    end
    tx_busy = 1'b0;
    rx_ready_mode = 1;
    for (n = 0; n < 60 * BOUND &&
         !(rx_q.size() == 0 && src_q.size() == 0 && tx_log.size() == exp_tx.size() && rcv_q.size() == exp_rx.size());
         n++) @(negedge clk);
    vectors += 2;
    if (tx_log.size() != exp_tx.size()) begin miscompares++; $display("FAIL rand_tx_count: got %0d writes want %0d", tx_log.size(), exp_tx.size()); end
    if (rcv_q.size() != exp_rx.size()) begin miscompares++; $display("FAIL rand_rx_count: got %0d bytes want %0d", rcv_q.size(), exp_rx.size()); end
    for (int i = 0; i < tx_log.size() && i < exp_tx.size(); i++) begin
      vectors++;
      if (tx_log[i] !== exp_tx[i]) begin miscompares++; $display("FAIL rand_tx[%0d]: got %0h want %0h", i, tx_log[i], exp_tx[i]); end
    end
    for (int i = 0; i < rcv_q.size() && i < exp_rx.size(); i++) begin
      vectors++;
      if (rcv_q[i] !== exp_rx[i]) begin miscompares++; $display("FAIL rand_rx[%0d]: got %0h want %0h", i, rcv_q[i], exp_rx[i]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_tx_single();
    test_tx_busy();
    test_rx_single();
    test_alternate();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
